async_fifo_wr_ctrl: RTL and testbench

Write-side pointer and flag controller for the async FIFO, one per write clock domain. Accepts write requests and advances the binary write pointer. Publishes a registered Gray write pointer to the read domain. Synchronises the incoming Gray read pointer, converts it to binary, and derives registered full, almost-full, fill-level and overflow status. Its Gray output feeds the read domain's synchroniser; its RAM address feeds the dual-port memory.

---
 rtl/async_fifo_wr_ctrl.sv | 96 +++++++++
 tb/tb_async_fifo_wr_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/async_fifo_wr_ctrl.sv
// Write-side pointer and flag controller for a dual-clock FIFO: owns the binary/Gray
// write pointer, synchronises the read pointer and derives registered fill status.
module async_fifo_wr_ctrl #(
    parameter int ADDR_WIDTH   = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = 2**ADDR_WIDTH - 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH:0]   rd_gray,
    output logic                  wr_fire,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH:0]   wr_gray,
    output logic [ADDR_WIDTH:0]   wr_count,
    output logic                  full,
    output logic                  almost_full,
    output logic                  overflow
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH_V = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [PW-1:0] AFULL_V = PW'(AFULL_THRESH);

    logic [PW-1:0] wr_bin_q, wr_bin_d;
    logic [PW-1:0] wr_gray_q, wr_gray_d;
    logic [PW-1:0] wr_count_q, wr_count_d;
    logic          full_q, full_d;
    logic          afull_q, afull_d;
    logic          overflow_q, overflow_d;
    logic [PW-1:0] sync_q [SYNC_STAGES];
    logic [PW-1:0] rd_bin_s;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        for (int i = 0; i < PW; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    // Handshake: wr_en is a request held by the producer; it is accepted (wr_fire)
    // in any cycle where full is low. A request while full is dropped and only
    // recorded in the sticky overflow flag.
    assign wr_fire = wr_en & ~full_q;

    always_comb begin
        wr_bin_d   = wr_bin_q + {{(PW-1){1'b0}}, wr_fire};
        wr_gray_d  = wr_bin_d ^ (wr_bin_d >> 1);
        rd_bin_s   = gray2bin(sync_q[SYNC_STAGES-1]);
        wr_count_d = wr_bin_d - rd_bin_s;
        full_d     = (wr_count_d == DEPTH_V);
        afull_d    = (wr_count_d >= AFULL_V);
        overflow_d = overflow_q | (wr_en & full_q);
    end

    // Pure flop chain: nothing may sit between stages or metastability settling time is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= rd_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bin_q   <= '0;
            wr_gray_q  <= '0;
            wr_count_q <= '0;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_bin_q   <= wr_bin_d;
            wr_gray_q  <= wr_gray_d;
            wr_count_q <= wr_count_d;
            full_q     <= full_d;
            afull_q    <= afull_d;
            overflow_q <= overflow_d;
        end
    end

    assign wr_addr     = wr_bin_q[ADDR_WIDTH-1:0];
    assign wr_gray     = wr_gray_q;
    assign wr_count    = wr_count_q;
    assign full        = full_q;
    assign almost_full = afull_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Directed bench for async_fifo_wr_ctrl (ADDR_WIDTH=4, SYNC_STAGES=2, AFULL_THRESH=14).
module tb_async_fifo_wr_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [4:0] rd_gray;
    logic       wr_fire;
    logic [3:0] wr_addr;
    logic [4:0] wr_gray;
    logic [4:0] wr_count;
    logic       full;
    logic       almost_full;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    logic [4:0] exp_q[$];

    async_fifo_wr_ctrl #(
        .ADDR_WIDTH(4),
        .SYNC_STAGES(2),
        .AFULL_THRESH(14)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .rd_gray(rd_gray),
        .wr_fire(wr_fire),
        .wr_addr(wr_addr),
        .wr_gray(wr_gray),
        .wr_count(wr_count),
        .full(full),
        .almost_full(almost_full),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] gray5(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; wr_en = 1'b0; rd_gray = 5'd0;
        #1 rst = 1'b1;
        #1;
        checks++; if (wr_count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", wr_count); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_afull got %b want 0", almost_full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
        checks++; if (wr_gray !== 5'd0) begin errors++; $display("FAIL reset_gray got %b want 00000", wr_gray); end
        checks++; if (wr_addr !== 4'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", wr_addr); end
        checks++; if (wr_fire !== 1'b0) begin errors++; $display("FAIL reset_fire got %b want 0", wr_fire); end
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_fill();
        logic [4:0] lv;
        wr_en = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            #1;
            checks++; if (wr_fire !== (k <= 16)) begin errors++; $display("FAIL fill_fire k=%0d got %b want %b", k, wr_fire, (k <= 16)); end
            tick();
            lv = (k > 16) ? 5'd16 : 5'(k);
            checks++; if (wr_count !== lv) begin errors++; $display("FAIL fill_count k=%0d got %0d want %0d", k, wr_count, lv); end
            checks++; if (full !== (lv == 5'd16)) begin errors++; $display("FAIL fill_full k=%0d got %b want %b", k, full, (lv == 5'd16)); end
            checks++; if (almost_full !== (lv >= 5'd14)) begin errors++; $display("FAIL fill_afull k=%0d got %b want %b", k, almost_full, (lv >= 5'd14)); end
            checks++; if (overflow !== (k == 17)) begin errors++; $display("FAIL fill_overflow k=%0d got %b want %b", k, overflow, (k == 17)); end
            checks++; if (wr_addr !== lv[3:0]) begin errors++; $display("FAIL fill_addr k=%0d got %0d want %0d", k, wr_addr, lv[3:0]); end
            checks++; if (wr_gray !== gray5(lv)) begin errors++; $display("FAIL fill_gray k=%0d got %b want %b", k, wr_gray, gray5(lv)); end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_drain();
        rd_gray = 5'b00010;
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c < 3) begin
                checks++; if (full !== 1'b1) begin errors++; $display("FAIL drain_early_full c=%0d got %b want 1", c, full); end
                checks++; if (wr_count !== 5'd16) begin errors++; $display("FAIL drain_early_count c=%0d got %0d want 16", c, wr_count); end
            end else begin
                checks++; if (wr_count !== 5'd13) begin errors++; $display("FAIL drain_count got %0d want 13", wr_count); end
                checks++; if (full !== 1'b0) begin errors++; $display("FAIL drain_full got %b want 0", full); end
                checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL drain_afull got %b want 0", almost_full); end
                checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL drain_overflow got %b want 1", overflow); end
            end
        end
    endtask

    task automatic test_simultaneous();
        rd_gray = gray5(5'd6);
        tick(); tick(); tick();
        checks++; if (wr_count !== 5'd10) begin errors++; $display("FAIL simul_setup_count got %0d want 10", wr_count); end
        rd_gray = gray5(5'd7);
        tick();
        checks++; if (wr_count !== 5'd10) begin errors++; $display("FAIL simul_t1_count got %0d want 10", wr_count); end
        tick();
        checks++; if (wr_count !== 5'd10) begin errors++; $display("FAIL simul_t2_count got %0d want 10", wr_count); end
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        checks++; if (wr_count !== 5'd10) begin errors++; $display("FAIL simul_t3_count got %0d want 10", wr_count); end
        checks++; if (wr_addr !== 4'd1) begin errors++; $display("FAIL simul_addr got %0d want 1", wr_addr); end
        checks++; if (wr_gray !== 5'b11001) begin errors++; $display("FAIL simul_gray got %b want 11001", wr_gray); end
        tick();
        checks++; if (wr_count !== 5'd10) begin errors++; $display("FAIL simul_t4_count got %0d want 10", wr_count); end
    endtask

    task automatic test_async_reset();
        rd_gray = gray5(5'd10);
        tick(); tick(); tick();
        checks++; if (wr_count !== 5'd7) begin errors++; $display("FAIL areset_setup_count got %0d want 7", wr_count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL areset_setup_overflow got %b want 1", overflow); end
        #2 rst = 1'b1;
        #1;
        checks++; if (wr_count !== 5'd0) begin errors++; $display("FAIL areset_count got %0d want 0", wr_count); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL areset_full got %b want 0", full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL areset_overflow got %b want 0", overflow); end
        checks++; if (wr_gray !== 5'd0) begin errors++; $display("FAIL areset_gray got %b want 00000", wr_gray); end
        checks++; if (wr_addr !== 4'd0) begin errors++; $display("FAIL areset_addr got %0d want 0", wr_addr); end
        rd_gray = 5'd0;
        #1 rst = 1'b0;
        tick();
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        checks++; if (wr_gray !== 5'b00001) begin errors++; $display("FAIL areset_first_gray got %b want 00001", wr_gray); end
        checks++; if (wr_count !== 5'd1) begin errors++; $display("FAIL areset_first_count got %0d want 1", wr_count); end
        checks++; if (wr_addr !== 4'd1) begin errors++; $display("FAIL areset_first_addr got %0d want 1", wr_addr); end
    endtask

    task automatic test_wrap();
        logic [4:0] exp_g;
        logic [4:0] prev_g;
        logic [4:0] exp_lv;
        rst = 1'b1; rd_gray = 5'd0; wr_en = 1'b0;
        #2 rst = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            exp_q.push_back(gray5(5'(n)));
        end
        prev_g = 5'd0;
        wr_en = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            tick();
            exp_g = exp_q.pop_front();
            exp_lv = (n < 7) ? 5'(n) : 5'd7;
            checks++; if (wr_gray !== exp_g) begin errors++; $display("FAIL wrap_gray n=%0d got %b want %b", n, wr_gray, exp_g); end
            checks++; if (wr_addr !== 4'(n % 16)) begin errors++; $display("FAIL wrap_addr n=%0d got %0d want %0d", n, wr_addr, n % 16); end
            checks++; if ($countones(wr_gray ^ prev_g) != 1) begin errors++; $display("FAIL wrap_onebit n=%0d got %b after %b want one bit flip", n, wr_gray, prev_g); end
            checks++; if (full !== 1'b0) begin errors++; $display("FAIL wrap_full n=%0d got %b want 0", n, full); end
            checks++; if (wr_count !== exp_lv) begin errors++; $display("FAIL wrap_count n=%0d got %0d want %0d", n, wr_count, exp_lv); end
            prev_g = wr_gray;
            rd_gray = (n >= 4) ? gray5(5'(n - 4)) : 5'd0;
        end
        wr_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_async_reset();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
